mmio_csr_bank_array: RTL and testbench



---
 rtl/mmio_pkg.sv | 41 ++++
 rtl/bram.sv | 20 ++
 rtl/delay.sv | 27 ++
 rtl/mmio_addr_decode.sv | 53 +++++
 rtl/mmio_csr_bank_array.sv | 147 ++++++++++++++
 tb/tb_mmio_csr_bank_array.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mmio_pkg.sv
// Shared MMIO widths, fixed register map, DFH constant and BRAM window helpers
// for the CSR/BRAM MMIO slave.
package mmio_pkg;
    localparam int ADDR_W = 16;
    localparam int TID_W  = 9;
    localparam int DATA_W = 64;

    localparam logic [ADDR_W-1:0] ADDR_DFH      = 16'h0000;
    localparam logic [ADDR_W-1:0] ADDR_AFU_ID_L = 16'h0002;
    localparam logic [ADDR_W-1:0] ADDR_AFU_ID_H = 16'h0004;
    localparam logic [ADDR_W-1:0] ADDR_WR_COUNT = 16'h0010;
    localparam logic [ADDR_W-1:0] ADDR_CONFIG   = 16'h0012;

    // AFU type, end-of-list set, no successor, zero feature id
    localparam logic [DATA_W-1:0] DFH_WORD =
        {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0};

    typedef enum logic [2:0] {
        REG_NONE,
        REG_DFH,
        REG_AFU_L,
        REG_AFU_H,
        REG_WR_COUNT,
        REG_CONFIG,
        REG_CSR,
        REG_BRAM
    } region_t;

    typedef struct packed {
        logic              valid;
        logic [TID_W-1:0]  tid;
        logic              sel_bram;
        logic [DATA_W-1:0] data;
    } rd_stage_t;

    // 64-bit word offset into the BRAM window; bank and word are its upper/lower fields
    function automatic logic [ADDR_W-1:0] bram_word_offset(input logic [ADDR_W-1:0] addr,
                                                           input logic [ADDR_W-1:0] base);
        return (addr - base) >> 1;
    endfunction
endpackage

// File: rtl/bram.sv
// Simple dual-port block RAM: one write port, one registered read port (1-cycle latency).
module bram #(
    parameter int WORDS = 512,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/delay.sv
// Resettable shift-register delay line; DEPTH = 0 degenerates to a wire.
module delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    if (DEPTH == 0) begin : g_wire
        assign q = d;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end
endmodule

// File: rtl/mmio_addr_decode.sv
// Combinational MMIO address decode: region, user CSR index, BRAM bank and word.
module mmio_addr_decode
    import mmio_pkg::*;
#(
    parameter int                NUM_CSR    = 4,
    parameter logic [ADDR_W-1:0] CSR_BASE   = 16'h0020,
    parameter int                NUM_BANKS  = 2,
    parameter int                BANK_WORDS = 512,
    parameter logic [ADDR_W-1:0] BRAM_BASE  = 16'h0100,
    parameter int                CSR_W      = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1,
    parameter int                BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    parameter int                WORD_W     = $clog2(BANK_WORDS)
) (
    input  logic [ADDR_W-1:0] addr,
    output region_t           region,
    output logic [CSR_W-1:0]  csr_idx,
    output logic [BANK_W-1:0] bank,
    output logic [WORD_W-1:0] word
);
    localparam logic [31:0] CSR_LO  = {16'h0, CSR_BASE};
    localparam logic [31:0] CSR_HI  = CSR_LO + 32'(2 * NUM_CSR);
    localparam logic [31:0] BRAM_LO = {16'h0, BRAM_BASE};
    localparam logic [31:0] BRAM_HI = BRAM_LO + 32'(2 * NUM_BANKS * BANK_WORDS);

    logic [31:0]       addr32;
    logic [ADDR_W-1:0] off;

    assign addr32 = {16'h0, addr};
    assign off    = bram_word_offset(addr, BRAM_BASE);

    always_comb begin
        region  = REG_NONE;
        csr_idx = CSR_W'((addr - CSR_BASE) >> 1);
        bank    = BANK_W'(off >> WORD_W);
        word    = WORD_W'(off);
        if (addr[0]) begin
            region = REG_NONE;
        end else if (addr32 >= CSR_LO && addr32 < CSR_HI) begin
            region = REG_CSR;
        end else if (addr32 >= BRAM_LO && addr32 < BRAM_HI) begin
            region = REG_BRAM;
        end else begin
            case (addr)
                ADDR_DFH:      region = REG_DFH;
                ADDR_AFU_ID_L: region = REG_AFU_L;
                ADDR_AFU_ID_H: region = REG_AFU_H;
                ADDR_WR_COUNT: region = REG_WR_COUNT;
                ADDR_CONFIG:   region = REG_CONFIG;
                default:       region = REG_NONE;
            endcase
        end
    end
endmodule

// File: rtl/mmio_csr_bank_array.sv
// CCI-P MMIO slave: DFH/AFU_ID, user CSRs, status registers and BRAM banks,
// with every read answered a fixed RD_LATENCY cycles after its request.
module mmio_csr_bank_array
    import mmio_pkg::*;
#(
    parameter int                NUM_CSR    = 4,
    parameter logic [ADDR_W-1:0] CSR_BASE   = 16'h0020,
    parameter int                NUM_BANKS  = 2,
    parameter int                BANK_WORDS = 512,
    parameter logic [ADDR_W-1:0] BRAM_BASE  = 16'h0100,
    parameter int                RD_LATENCY = 3,
    parameter logic [127:0]      AFU_ID     = 128'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mmio_rd_valid,
    input  logic                      mmio_wr_valid,
    input  logic [ADDR_W-1:0]         mmio_addr,
    input  logic [TID_W-1:0]          mmio_tid,
    input  logic [DATA_W-1:0]         mmio_wr_data,
    output logic                      rsp_valid,
    output logic [TID_W-1:0]          rsp_tid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [NUM_CSR*DATA_W-1:0] csr_q
);
    localparam int CSR_W  = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int WORD_W = $clog2(BANK_WORDS);

    localparam logic [31:0] CSR_LO  = {16'h0, CSR_BASE};
    localparam logic [31:0] CSR_HI  = CSR_LO + 32'(2 * NUM_CSR);
    localparam logic [31:0] BRAM_LO = {16'h0, BRAM_BASE};
    localparam logic [31:0] BRAM_HI = BRAM_LO + 32'(2 * NUM_BANKS * BANK_WORDS);

    if (CSR_LO < 32'h14) begin : g_err_csr_fixed
        $error("user CSR range overlaps the fixed registers 0x0000..0x0013");
    end
    if (CSR_LO < BRAM_HI && BRAM_LO < CSR_HI) begin : g_err_csr_bram
        $error("user CSR range overlaps the BRAM window");
    end
    if (BRAM_HI > 32'h1_0000) begin : g_err_bram_top
        $error("BRAM window extends past address 0xFFFF");
    end
    if (RD_LATENCY < 2) begin : g_err_latency
        $error("RD_LATENCY must be at least 2");
    end

    region_t           region;
    logic [CSR_W-1:0]  csr_idx;
    logic [BANK_W-1:0] bank;
    logic [WORD_W-1:0] word;

    mmio_addr_decode #(
        .NUM_CSR(NUM_CSR), .CSR_BASE(CSR_BASE), .NUM_BANKS(NUM_BANKS),
        .BANK_WORDS(BANK_WORDS), .BRAM_BASE(BRAM_BASE),
        .CSR_W(CSR_W), .BANK_W(BANK_W), .WORD_W(WORD_W)
    ) u_decode (
        .addr(mmio_addr), .region(region), .csr_idx(csr_idx), .bank(bank), .word(word)
    );

    logic wr_hit;
    logic rd_accept;

    assign wr_hit    = mmio_wr_valid && (region == REG_CSR || region == REG_BRAM);
    // A read colliding with a write is dropped; the write still happens
    assign rd_accept = mmio_rd_valid && !mmio_wr_valid;

    logic [NUM_CSR-1:0][DATA_W-1:0] csr_r;
    logic [31:0]                    wr_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csr_r    <= '0;
            wr_count <= '0;
        end else begin
            if (wr_hit) wr_count <= wr_count + 32'd1;
            if (mmio_wr_valid && region == REG_CSR) csr_r[csr_idx] <= mmio_wr_data;
        end
    end

    assign csr_q = csr_r;

    logic [DATA_W-1:0] reg_data;

    always_comb begin
        reg_data = '0;
        case (region)
            REG_DFH:      reg_data = DFH_WORD;
            REG_AFU_L:    reg_data = AFU_ID[63:0];
            REG_AFU_H:    reg_data = AFU_ID[127:64];
            REG_WR_COUNT: reg_data = {32'h0, wr_count};
            REG_CONFIG:   reg_data = {16'(NUM_BANKS), 32'(BANK_WORDS), 16'(NUM_CSR)};
            REG_CSR:      reg_data = csr_r[csr_idx];
            default:      reg_data = '0;
        endcase
    end

    rd_stage_t rd_in;
    rd_stage_t rd_out;

    assign rd_in = '{valid: rd_accept, tid: mmio_tid, sel_bram: (region == REG_BRAM), data: reg_data};

    delay #(.WIDTH($bits(rd_stage_t)), .DEPTH(RD_LATENCY)) u_rd_pipe (
        .clk(clk), .rst(rst), .d(rd_in), .q(rd_out)
    );

    // BRAM path: registered address, 1-cycle RAM, then padded up to RD_LATENCY
    logic [WORD_W-1:0] rd_word_q;
    logic [BANK_W-1:0] rd_bank_q;
    logic [BANK_W-1:0] rd_bank_q2;
    logic [DATA_W-1:0] bank_rdata [NUM_BANKS];
    logic [DATA_W-1:0] bram_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_word_q  <= '0;
            rd_bank_q  <= '0;
            rd_bank_q2 <= '0;
        end else begin
            rd_word_q  <= word;
            rd_bank_q  <= bank;
            rd_bank_q2 <= rd_bank_q;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        bram #(.WORDS(BANK_WORDS), .WIDTH(DATA_W)) u_bram (
            .clk(clk),
            .we(mmio_wr_valid && region == REG_BRAM && bank == BANK_W'(b)),
            .waddr(word),
            .wdata(mmio_wr_data),
            .raddr(rd_word_q),
            .rdata(bank_rdata[b])
        );
    end

    delay #(.WIDTH(DATA_W), .DEPTH(RD_LATENCY - 2)) u_bram_pad (
        .clk(clk), .rst(rst), .d(bank_rdata[rd_bank_q2]), .q(bram_data)
    );

    assign rsp_valid = rd_out.valid;
    assign rsp_tid   = rd_out.tid;
    assign rsp_data  = rd_out.valid ? (rd_out.sel_bram ? bram_data : rd_out.data) : '0;

    rd_wr_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(mmio_rd_valid && mmio_wr_valid));
endmodule

// File: tb/tb_mmio_csr_bank_array.sv
// Bench: two builds (latency 3 / 2 banks, latency 5 / 4 banks) share one MMIO
// stimulus stream; responses are scored against an address-map model.
module tb_mmio_csr_bank_array;
    localparam logic [127:0] AFU = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_ABCD;

    typedef struct packed {
        int          cyc;
        logic [8:0]  tid;
        logic [63:0] data;
        bit          dc;
    } rsp_t;

    logic         clk = 0;
    logic         rst = 1;
    logic         mmio_rd_valid = 0;
    logic         mmio_wr_valid = 0;
    logic [15:0]  mmio_addr = 0;
    logic [8:0]   mmio_tid = 0;
    logic [63:0]  mmio_wr_data = 0;
    logic         rsp_valid_a, rsp_valid_b;
    logic [8:0]   rsp_tid_a, rsp_tid_b;
    logic [63:0]  rsp_data_a, rsp_data_b;
    logic [255:0] csr_q_a, csr_q_b;

    mmio_csr_bank_array #(.AFU_ID(AFU)) u_dut_a (
        .clk(clk), .rst(rst), .mmio_rd_valid(mmio_rd_valid), .mmio_wr_valid(mmio_wr_valid),
        .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wr_data(mmio_wr_data),
        .rsp_valid(rsp_valid_a), .rsp_tid(rsp_tid_a), .rsp_data(rsp_data_a), .csr_q(csr_q_a)
    );

    mmio_csr_bank_array #(.AFU_ID(AFU), .RD_LATENCY(5), .NUM_BANKS(4)) u_dut_b (
        .clk(clk), .rst(rst), .mmio_rd_valid(mmio_rd_valid), .mmio_wr_valid(mmio_wr_valid),
        .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wr_data(mmio_wr_data),
        .rsp_valid(rsp_valid_b), .rsp_tid(rsp_tid_b), .rsp_data(rsp_data_b), .csr_q(csr_q_b)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          zero_viol = 0;
    logic [8:0]  tid_ctr = 0;
    int          lat [2];
    int          nb [2];
    rsp_t        exp_q [2][$];
    rsp_t        log_q [2][$];
    logic [63:0] m_csr [2][4];
    logic [31:0] m_wcnt [2];
    logic [63:0] m_bram [int];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rsp_valid_a) log_q[0].push_back('{cyc: cyc, tid: rsp_tid_a, data: rsp_data_a, dc: 1'b0});
        else if (rsp_data_a !== 64'h0) zero_viol++;
        if (rsp_valid_b) log_q[1].push_back('{cyc: cyc, tid: rsp_tid_b, data: rsp_data_b, dc: 1'b0});
        else if (rsp_data_b !== 64'h0) zero_viol++;
    end

    function automatic bit in_window(int k, logic [15:0] a);
        return int'(a) >= 'h100 && int'(a) < 'h100 + 2 * nb[k] * 512;
    endfunction

    function automatic logic [63:0] model_read(int k, logic [15:0] a, output bit dc);
        int key;
        dc = 1'b0;
        if (a[0]) return 64'h0;
        if (a == 16'h0000) return 64'h1000_0100_0000_0000;
        if (a == 16'h0002) return AFU[63:0];
        if (a == 16'h0004) return AFU[127:64];
        if (a == 16'h0010) return {32'h0, m_wcnt[k]};
        if (a == 16'h0012) return {16'(nb[k]), 32'd512, 16'd4};
        if (a >= 16'h0020 && a < 16'h0028) return m_csr[k][(int'(a) - 32) / 2];
        if (in_window(k, a)) begin
            key = k * 65536 + (int'(a) - 'h100) / 2;
            if (m_bram.exists(key)) return m_bram[key];
            dc = 1'b1;
        end
        return 64'h0;
    endfunction

    function automatic void model_write(int k, logic [15:0] a, logic [63:0] d);
        if (a[0]) return;
        if (a >= 16'h0020 && a < 16'h0028) begin
            m_csr[k][(int'(a) - 32) / 2] = d;
            m_wcnt[k] = m_wcnt[k] + 32'd1;
        end else if (in_window(k, a)) begin
            m_bram[k * 65536 + (int'(a) - 'h100) / 2] = d;
            m_wcnt[k] = m_wcnt[k] + 32'd1;
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_wcnt[k] = 32'h0;
            for (int i = 0; i < 4; i++) m_csr[k][i] = 64'h0;
        end
    endfunction

    task automatic op(input bit rd, input bit wr, input logic [15:0] a, input logic [63:0] d);
        bit          dc;
        logic [63:0] v;
        @(negedge clk);
        mmio_rd_valid = rd;
        mmio_wr_valid = wr;
        mmio_addr     = a;
        mmio_wr_data  = d;
        mmio_tid      = tid_ctr;
        for (int k = 0; k < 2; k++) begin
            if (rd) begin
                v = model_read(k, a, dc);
                exp_q[k].push_back('{cyc: cyc + lat[k], tid: tid_ctr, data: v, dc: dc});
            end
            if (wr) model_write(k, a, d);
        end
        tid_ctr = tid_ctr + 9'd1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        mmio_rd_valid = 1'b0;
        mmio_wr_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic start_test();
        for (int k = 0; k < 2; k++) begin
            exp_q[k].delete();
            log_q[k].delete();
        end
    endtask

    task automatic test_reset();
        #3;
        vectors += 4;
        if (rsp_valid_a !== 1'b0 || rsp_valid_b !== 1'b0) begin
            miscompares++; $display("FAIL reset rsp_valid: got %b/%b, want 0/0", rsp_valid_a, rsp_valid_b);
        end
        if (rsp_tid_a !== 9'h0 || rsp_tid_b !== 9'h0) begin
            miscompares++; $display("FAIL reset rsp_tid: got %h/%h, want 0/0", rsp_tid_a, rsp_tid_b);
        end
        if (rsp_data_a !== 64'h0 || rsp_data_b !== 64'h0) begin
            miscompares++; $display("FAIL reset rsp_data: got %h/%h, want 0/0", rsp_data_a, rsp_data_b);
        end
        if (csr_q_a !== 256'h0 || csr_q_b !== 256'h0) begin
            miscompares++; $display("FAIL reset csr_q: got %h / %h, want 0", csr_q_a, csr_q_b);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_test();
        op(1, 0, 16'h0010, 0);
        op(1, 0, 16'h0012, 0);
        idle(8);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (log_q[k].size() != exp_q[k].size()) begin
                miscompares++;
                $display("FAIL reset_regs dut%0d rsp count: got %0d, want %0d", k, log_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < log_q[k].size(); i++) begin
                vectors++;
                if (log_q[k][i].cyc != exp_q[k][i].cyc || log_q[k][i].tid !== exp_q[k][i].tid ||
                    log_q[k][i].data !== exp_q[k][i].data) begin
                    miscompares++;
                    $display("FAIL reset_regs dut%0d rsp%0d: got cyc %0d tid %0d data %h, want cyc %0d tid %0d data %h",
                             k, i, log_q[k][i].cyc, log_q[k][i].tid, log_q[k][i].data,
                             exp_q[k][i].cyc, exp_q[k][i].tid, exp_q[k][i].data);
                end
            end
        end
    endtask

    task automatic test_id_regs();
        start_test();
        op(1, 0, 16'h0000, 0); idle(2);
        op(1, 0, 16'h0002, 0); idle(2);
        op(1, 0, 16'h0004, 0);
        op(1, 0, 16'h0006, 0);
        op(1, 0, 16'h0008, 0);
        idle(8);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (log_q[k].size() != exp_q[k].size()) begin
                miscompares++;
                $display("FAIL id_regs dut%0d rsp count: got %0d, want %0d", k, log_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < log_q[k].size(); i++) begin
                vectors++;
                if (log_q[k][i].cyc != exp_q[k][i].cyc || log_q[k][i].tid !== exp_q[k][i].tid ||
                    log_q[k][i].data !== exp_q[k][i].data) begin
                    miscompares++;
                    $display("FAIL id_regs dut%0d rsp%0d: got cyc %0d tid %0d data %h, want cyc %0d tid %0d data %h",
                             k, i, log_q[k][i].cyc, log_q[k][i].tid, log_q[k][i].data,
                             exp_q[k][i].cyc, exp_q[k][i].tid, exp_q[k][i].data);
                end
            end
        end
    endtask

    task automatic test_csr_rw();
        logic [255:0] exp_csr;
        start_test();
        op(0, 1, 16'h0022, 64'hDEAD_BEEF);
        op(1, 0, 16'h0022, 0);
        op(1, 0, 16'h0010, 0);
        op(0, 1, 16'h0026, 64'h0123_4567_89AB_CDEF);
        op(0, 1, 16'h0028, 64'hFFFF_0000_FFFF_0000);
        op(1, 0, 16'h0026, 0);
        op(1, 0, 16'h0028, 0);
        op(1, 0, 16'h0010, 0);
        idle(8);
        vectors++;
        if (csr_q_a[127:64] !== 64'hDEAD_BEEF) begin
            miscompares++; $display("FAIL csr_q[1]: got %h, want %h", csr_q_a[127:64], 64'hDEAD_BEEF);
        end
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) exp_csr[64*i +: 64] = m_csr[k][i];
            vectors++;
            if ((k == 0 ? csr_q_a : csr_q_b) !== exp_csr) begin
                miscompares++;
                $display("FAIL csr_q dut%0d: got %h, want %h", k, (k == 0 ? csr_q_a : csr_q_b), exp_csr);
            end
            vectors++;
            if (log_q[k].size() != exp_q[k].size()) begin
                miscompares++;
                $display("FAIL csr_rw dut%0d rsp count: got %0d, want %0d", k, log_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < log_q[k].size(); i++) begin
                vectors++;
                if (log_q[k][i].cyc != exp_q[k][i].cyc || log_q[k][i].tid !== exp_q[k][i].tid ||
                    log_q[k][i].data !== exp_q[k][i].data) begin
                    miscompares++;
                    $display("FAIL csr_rw dut%0d rsp%0d: got cyc %0d tid %0d data %h, want cyc %0d tid %0d data %h",
                             k, i, log_q[k][i].cyc, log_q[k][i].tid, log_q[k][i].data,
                             exp_q[k][i].cyc, exp_q[k][i].tid, exp_q[k][i].data);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd_addr [8];
        rd_addr = '{16'h0100, 16'h04FE, 16'h0500, 16'h08FE, 16'h0100, 16'h08FE, 16'h0500, 16'h04FE};
        start_test();
        op(0, 1, 16'h04FE, 64'h11);
        op(0, 1, 16'h0500, 64'h22);
        op(0, 1, 16'h08FE, 64'hA5);
        op(0, 1, 16'h0100, 64'h5A);
        op(0, 1, 16'h0D00, 64'h3D);
        for (int i = 0; i < 8; i++) op(1, 0, rd_addr[i], 0);
        op(1, 0, 16'h0D00, 0);
        op(1, 0, 16'h0010, 0);
        idle(8);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (log_q[k].size() != exp_q[k].size()) begin
                miscompares++;
                $display("FAIL back_to_back dut%0d rsp count: got %0d, want %0d", k, log_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < log_q[k].size(); i++) begin
                vectors++;
                if (log_q[k][i].cyc != exp_q[k][i].cyc || log_q[k][i].tid !== exp_q[k][i].tid ||
                    log_q[k][i].data !== exp_q[k][i].data) begin
                    miscompares++;
                    $display("FAIL back_to_back dut%0d rsp%0d: got cyc %0d tid %0d data %h, want cyc %0d tid %0d data %h",
                             k, i, log_q[k][i].cyc, log_q[k][i].tid, log_q[k][i].data,
                             exp_q[k][i].cyc, exp_q[k][i].tid, exp_q[k][i].data);
                end
            end
        end
    endtask

    task automatic test_unmapped();
        start_test();
        op(1, 0, 16'h0900, 0);
        op(1, 0, 16'h0023, 0);
        op(0, 1, 16'h0002, 64'hBAD0_BAD0_BAD0_BAD0);
        op(0, 1, 16'h0010, 64'h1234);
        op(0, 1, 16'h0021, 64'h77);
        op(1, 0, 16'h0002, 0);
        op(1, 0, 16'h0010, 0);
        op(1, 0, 16'h0020, 0);
        op(1, 0, 16'hFFFE, 0);
        op(1, 0, 16'h0014, 0);
        idle(8);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (log_q[k].size() != exp_q[k].size()) begin
                miscompares++;
                $display("FAIL unmapped dut%0d rsp count: got %0d, want %0d", k, log_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < log_q[k].size(); i++) begin
                vectors++;
                if (log_q[k][i].cyc != exp_q[k][i].cyc || log_q[k][i].tid !== exp_q[k][i].tid ||
                    (!exp_q[k][i].dc && log_q[k][i].data !== exp_q[k][i].data)) begin
                    miscompares++;
                    $display("FAIL unmapped dut%0d rsp%0d: got cyc %0d tid %0d data %h, want cyc %0d tid %0d data %h",
                             k, i, log_q[k][i].cyc, log_q[k][i].tid, log_q[k][i].data,
                             exp_q[k][i].cyc, exp_q[k][i].tid, exp_q[k][i].data);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        start_test();
        op(0, 1, 16'h0020, 64'h77);
        op(1, 0, 16'h0020, 0);
        op(1, 0, 16'h0000, 0);
        op(1, 0, 16'h0100, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mmio_rd_valid = 1'b0;
        mmio_wr_valid = 1'b0;
        start_test();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (csr_q_a !== 256'h0 || csr_q_b !== 256'h0) begin
            miscompares++; $display("FAIL reset_mid csr_q: got %h / %h, want 0", csr_q_a, csr_q_b);
        end
        op(1, 0, 16'h0010, 0);
        op(1, 0, 16'h0012, 0);
        op(1, 0, 16'h0100, 0);
        idle(8);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (log_q[k].size() != exp_q[k].size()) begin
                miscompares++;
                $display("FAIL reset_mid dut%0d rsp count: got %0d, want %0d", k, log_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < log_q[k].size(); i++) begin
                vectors++;
                if (log_q[k][i].cyc != exp_q[k][i].cyc || log_q[k][i].tid !== exp_q[k][i].tid ||
                    log_q[k][i].data !== exp_q[k][i].data) begin
                    miscompares++;
                    $display("FAIL reset_mid dut%0d rsp%0d: got cyc %0d tid %0d data %h, want cyc %0d tid %0d data %h",
                             k, i, log_q[k][i].cyc, log_q[k][i].tid, log_q[k][i].data,
                             exp_q[k][i].cyc, exp_q[k][i].tid, exp_q[k][i].data);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] pool [16];
        logic [15:0] a;
        int          sel;
        pool = '{16'h0000, 16'h0002, 16'h0004, 16'h0010, 16'h0012, 16'h001E, 16'h0020, 16'h0024,
                 16'h0026, 16'h0028, 16'h0100, 16'h04FE, 16'h0500, 16'h08FE, 16'h0900, 16'h10FE};
        start_test();
        for (int n = 0; n < 300; n++) begin
            a = pool[$urandom_range(0, 15)];
            if ($urandom_range(0, 7) == 0) a = a | 16'h0001;
            sel = $urandom_range(0, 9);
            if (sel < 5)      op(1, 0, a, 0);
            else if (sel < 8) op(0, 1, a, {$urandom, $urandom});
            else              idle(1);
        end
        idle(8);
        vectors++;
        if (zero_viol != 0) begin
            miscompares++; $display("FAIL rsp_data_idle: got %0d nonzero idle cycles, want 0", zero_viol);
        end
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (log_q[k].size() != exp_q[k].size()) begin
                miscompares++;
                $display("FAIL random dut%0d rsp count: got %0d, want %0d", k, log_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < log_q[k].size(); i++) begin
                vectors++;
                if (log_q[k][i].cyc != exp_q[k][i].cyc || log_q[k][i].tid !== exp_q[k][i].tid ||
                    (!exp_q[k][i].dc && log_q[k][i].data !== exp_q[k][i].data)) begin
                    miscompares++;
                    $display("FAIL random dut%0d rsp%0d: got cyc %0d tid %0d data %h, want cyc %0d tid %0d data %h",
                             k, i, log_q[k][i].cyc, log_q[k][i].tid, log_q[k][i].data,
                             exp_q[k][i].cyc, exp_q[k][i].tid, exp_q[k][i].data);
                end
            end
        end
    endtask

    initial begin
        lat[0] = 3; lat[1] = 5;
        nb[0]  = 2; nb[1]  = 4;
        test_reset();
        test_id_regs();
        test_csr_rw();
        test_back_to_back();
        test_unmapped();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
